video_sync_normalizer: RTL and testbench
========================================

# video_sync_normalizer

Front-end video conditioning stage that sits directly upstream of the horizontal scanline stage. It takes raw core video with arbitrary-polarity HS/VS plus separate H/V blanking. It auto-detects sync polarity, emits active-high HS/VS and a DE derived from blanking, and optionally re-times VS to the HS leading edge. All outputs share a fixed 2-clock latency so the scanline stage receives coherent RGB/HS/VS/DE/CE.

## Interface
- CNT_W, 12, width of each saturating polarity-measurement counter (HS counters count pixels, VS counters count lines)
- iPCLK  in  1  pixel clock; sole clock
- iRST_N  in  1  asynchronous, active-low reset
- iCE  in  1  core pixel clock enable
- iRGB  in  24  core RGB {R,G,B}
- iHS  in  1  core hsync, either polarity
- iVS  in  1  core vsync, either polarity
- iHBLANK  in  1  horizontal blanking, active-high
- iVBLANK  in  1  vertical blanking, active-high
- oRGB  out  24  RGB, delayed
- oHS  out  1  hsync, always active-high
- oVS  out  1  vsync, always active-high
- oDE  out  1  data enable = ~(HBLANK | VBLANK), delayed
- oCE  out  1  iCE delayed
- oHPOL  out  1  detected HS polarity; 1 = input active-low
- oVPOL  out  1  detected VS polarity; 1 = input active-low

## Operation
- Reset is asynchronous on iRST_N low and has priority over everything. It forces all outputs, pipeline registers, counters and edge-history registers to 0, so oHPOL=oVPOL=0 (active-high is assumed).
- **Edge history:**
  - hs_prev and vs_prev capture raw iHS and iVS on iCE=1 cycles only.
  - A raw rising edge of HS (hs_rise) is iCE & iHS & ~hs_prev. vs_rise is defined the same way from iVS and vs_prev.
- **HS polarity measurement:**
  - On each iCE cycle, increment hhi if iHS=1, otherwise increment hlo. Both counters saturate at 2^CNT_W−1.
  - On hs_rise, do not increment. Instead set hpol = (hhi > hlo), then clear both counters.
  - On a tie, hpol=0.
- **VS polarity measurement:** on each hs_rise, increment vhi if iVS=1, otherwise increment vlo, with the same saturation. On vs_rise, set vpol = (vhi > vlo) and clear both. If vs_rise and hs_rise occur in the same cycle, the compare uses the pre-increment values and the clear wins.
- **Normalization:** hs_n = iHS ^ hpol and vs_n = iVS ^ vpol, using the current polarity registers. A polarity change takes effect on the cycle after it is latched; a one-time sync glitch at the switch is accepted.
- **VS alignment (VIDEO_NORM_VSALIGN_EN):** vs_a updates to vs_n only on cycles where hs_n rises (iCE & hs_n & ~hs_n_prev) and is held otherwise.
- **DE:** de = ~(iHBLANK | iVBLANK), evaluated every clock.
- **Pipeline:** two register stages for RGB, hs_n, vs_a/vs_n, de and iCE. Both stages run every iPCLK cycle (not CE-gated), so the CE phase is preserved.

## Timing
- oRGB/oHS/oVS/oDE/oCE equal the inputs of cycle N at cycle N+2, for every clock.
- oHPOL/oVPOL are registered and change 1 clock after the deciding edge cycle.
- First valid HS polarity is available after the second iHS rising edge following reset. First valid VS polarity is available after the second iVS rising edge.
- **Saturation:** a line or frame longer than 2^CNT_W−1 units saturates the counters. The compare is still performed.
- Inputs with iCE=0 do not affect the counters or the edge history.

## Configuration
- VIDEO_NORM_VSALIGN_EN defined: oVS is vs_a, so VS edges occur only 2 clocks after a normalized-HS leading edge.
- Not defined: oVS is vs_n passed straight through the 2-stage pipeline, and the vs_a register is not built.

## Test plan
- **Reset:** drive iRST_N=0 mid-line with iHS=1, iRGB=0xFFFFFF.
  - Outputs are 0 immediately, without waiting for a clock edge.
  - After release, the first outputs appear 2 clocks later.
- **Active-low HS:** iCE=1 constantly, line = 800 clocks, iHS low for 96 clocks.
  - After the 2nd rising edge, oHPOL=1.
  - oHS is high for exactly 96 clocks per line.
- **Active-high VS:** 525-line frame with iVS high for 2 lines.
  - After the 2nd iVS rise, oVPOL=0.
  - oVS is high for 2 lines.
- **CE gating:** iCE=1 every 4th clock, 400 CE-cycles per line, HS low for 48 CE-cycles.
  - oHPOL=1.
  - oCE pattern equals iCE delayed 2 clocks.
- **DE/latency:** iHBLANK=0, iVBLANK=0, iRGB=0x123456 at cycle N.
  - oDE=1 and oRGB=0x123456 at N+2.
  - Setting iVBLANK=1 gives oDE=0 two clocks later.
- **VSALIGN:** with the macro defined, raise iVS 100 clocks after an HS leading edge (active-high HS).
  - oVS rises 2 clocks after the next normalized HS rise.
  - Without the macro, oVS rises 2 clocks after iVS.

Source files
------------

// File: rtl/video_sync_normalizer.sv
// video_sync_normalizer
//   Front-end conditioning ahead of the scanline stage. Learns the polarity of
//   raw HS/VS by comparing high vs low time between rising edges, emits
//   active-high HS/VS plus DE from blanking, and delays RGB/HS/VS/DE/CE by a
//   fixed 2 clocks so everything downstream stays coherent.
//
//   Optional feature macro: VIDEO_NORM_VSALIGN_EN
//     defined   : VS is re-timed so it only changes on a normalized-HS leading edge
//     undefined : VS is normalized and passed straight through the pipeline
//
// Ports
//   iPCLK    pixel clock (sole clock)
//   iRST_N   asynchronous active-low reset
//   iCE      core pixel clock enable
//   iRGB     core RGB {R,G,B}
//   iHS/iVS  core syncs, any polarity
//   iHBLANK/iVBLANK  active-high blanking
//   oRGB/oHS/oVS/oDE/oCE  2-clock delayed, HS/VS active-high
//   oHPOL/oVPOL  detected polarity, 1 = input is active-low
module video_sync_normalizer #(
    parameter int CNT_W = 12
) (
    input  logic        iPCLK,
    input  logic        iRST_N,
    input  logic        iCE,
    input  logic [23:0] iRGB,
    input  logic        iHS,
    input  logic        iVS,
    input  logic        iHBLANK,
    input  logic        iVBLANK,
    output logic [23:0] oRGB,
    output logic        oHS,
    output logic        oVS,
    output logic        oDE,
    output logic        oCE,
    output logic        oHPOL,
    output logic        oVPOL
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
        logic        ce;
    } stage_t;

    logic             hsPrev, vsPrev;
    logic             hsRise, vsRise;
    logic [CNT_W-1:0] hhi, hlo, vhi, vlo;
    logic             hpol, vpol;
    logic             hsN, vsN, vsOut;
    stage_t           stg1, stg2;

    assign hsRise = iCE & iHS & ~hsPrev;
    assign vsRise = iCE & iVS & ~vsPrev;

    // Edge history only advances on enabled pixels, so idle clocks between
    // CE pulses can never fabricate an edge.
    always_ff @(posedge iPCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hsPrev <= 1'b0;
            vsPrev <= 1'b0;
        end else if (iCE) begin
            hsPrev <= iHS;
            vsPrev <= iVS;
        end
    end

    // Pixel-domain measurement: per line, is HS mostly high or mostly low?
    // A sync that sits high most of the line is an active-low pulse.
    always_ff @(posedge iPCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hhi  <= '0;
            hlo  <= '0;
            hpol <= 1'b0;
        end else if (hsRise) begin
            hpol <= (hhi > hlo);
            hhi  <= '0;
            hlo  <= '0;
        end else if (iCE) begin
            if (iHS) begin
                if (hhi != CNT_MAX) hhi <= hhi + 1'b1;
            end else begin
                if (hlo != CNT_MAX) hlo <= hlo + 1'b1;
            end
        end
    end

    // Line-domain measurement for VS, sampled once per raw HS rise. When both
    // edges land together the decision uses the counts as they stood and the
    // clear takes precedence over that line's increment.
    always_ff @(posedge iPCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            vhi  <= '0;
            vlo  <= '0;
            vpol <= 1'b0;
        end else if (vsRise) begin
            vpol <= (vhi > vlo);
            vhi  <= '0;
            vlo  <= '0;
        end else if (hsRise) begin
            if (iVS) begin
                if (vhi != CNT_MAX) vhi <= vhi + 1'b1;
            end else begin
                if (vlo != CNT_MAX) vlo <= vlo + 1'b1;
            end
        end
    end

    assign hsN = iHS ^ hpol;
    assign vsN = iVS ^ vpol;

`ifdef VIDEO_NORM_VSALIGN_EN
    logic hsNPrev, vsAReg, hsNRise;

    assign hsNRise = iCE & hsN & ~hsNPrev;
    // Combinational select so the re-timed VS rides the same 2-clock pipe
    // as HS; the register only holds the value between HS leading edges.
    assign vsOut   = hsNRise ? vsN : vsAReg;

    always_ff @(posedge iPCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hsNPrev <= 1'b0;
            vsAReg  <= 1'b0;
        end else begin
            if (iCE) hsNPrev <= hsN;
            vsAReg <= vsOut;
        end
    end
`else
    assign vsOut = vsN;
`endif

    // Both stages clock every cycle (not CE-gated) so the CE phase relation
    // to the data is preserved downstream.
    always_ff @(posedge iPCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            stg1 <= '0;
            stg2 <= '0;
        end else begin
            stg1 <= '{rgb: iRGB, hs: hsN, vs: vsOut,
                      de: ~(iHBLANK | iVBLANK), ce: iCE};
            stg2 <= stg1;
        end
    end

    assign oRGB  = stg2.rgb;
    assign oHS   = stg2.hs;
    assign oVS   = stg2.vs;
    assign oDE   = stg2.de;
    assign oCE   = stg2.ce;
    assign oHPOL = hpol;
    assign oVPOL = vpol;

endmodule

// File: tb/tb_video_sync_normalizer.sv
module tb_video_sync_normalizer;

    localparam int CNT_W = 12;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic        iPCLK = 1'b0;
    logic        iRST_N, iCE, iHS, iVS, iHBLANK, iVBLANK;
    logic [23:0] iRGB;
    logic [23:0] oRGB;
    logic        oHS, oVS, oDE, oCE, oHPOL, oVPOL;

    video_sync_normalizer #(.CNT_W(CNT_W)) dut (
        .iPCLK(iPCLK), .iRST_N(iRST_N), .iCE(iCE), .iRGB(iRGB),
        .iHS(iHS), .iVS(iVS), .iHBLANK(iHBLANK), .iVBLANK(iVBLANK),
        .oRGB(oRGB), .oHS(oHS), .oVS(oVS), .oDE(oDE), .oCE(oCE),
        .oHPOL(oHPOL), .oVPOL(oVPOL)
    );

    always #5 iPCLK = ~iPCLK;

    int total = 0;
    int bad   = 0;
    int cycIdx = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 30)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycIdx);
        end
    endtask

    // ---------------- reference model ----------------
    // Polarity is decided from plain counts of high/low samples gathered
    // between rising edges, clipped to the counter range at decision time.
    typedef struct packed {
        logic [23:0] rgb;
        logic        hs, vs, de, ce;
    } tup_t;

    tup_t e1, e2;
    int   nHsHigh, nHsLow, nVsHigh, nVsLow;
    bit   mHpol, mVpol, mHsPrev, mVsPrev, mHsNPrev, mVsA;

    function automatic int clip(input int n);
        return (n > MAXC) ? MAXC : n;
    endfunction

    task automatic resetModel();
        e1 = '0; e2 = '0;
        nHsHigh = 0; nHsLow = 0; nVsHigh = 0; nVsLow = 0;
        mHpol = 0; mVpol = 0; mHsPrev = 0; mVsPrev = 0; mHsNPrev = 0; mVsA = 0;
    endtask

    task automatic modelStep();
        bit hr, vr, hn, vn, vOut;
        if (!iRST_N) begin
            resetModel();
            return;
        end
        hr = iCE & iHS & ~mHsPrev;
        vr = iCE & iVS & ~mVsPrev;
        hn = iHS ^ mHpol;
        vn = iVS ^ mVpol;
`ifdef VIDEO_NORM_VSALIGN_EN
        if (iCE && hn && !mHsNPrev) mVsA = vn;
        vOut = mVsA;
        if (iCE) mHsNPrev = hn;
`else
        vOut = vn;
`endif
        e2 = e1;
        e1 = '{rgb: iRGB, hs: hn, vs: vOut, de: ~(iHBLANK | iVBLANK), ce: iCE};
        if (vr) begin
            mVpol = clip(nVsHigh) > clip(nVsLow);
            nVsHigh = 0; nVsLow = 0;
        end else if (hr) begin
            if (iVS) nVsHigh++; else nVsLow++;
        end
        if (hr) begin
            mHpol = clip(nHsHigh) > clip(nHsLow);
            nHsHigh = 0; nHsLow = 0;
        end else if (iCE) begin
            if (iHS) nHsHigh++; else nHsLow++;
        end
        if (iCE) begin
            mHsPrev = iHS;
            mVsPrev = iVS;
        end
    endtask

    // One clock: model advances on the edge, outputs sampled 1 time unit later.
    task automatic cyc();
        @(posedge iPCLK);
        modelStep();
        #1;
        cycIdx++;
        chk("oRGB",  32'(oRGB),  32'(e2.rgb));
        chk("oHS",   32'(oHS),   32'(e2.hs));
        chk("oVS",   32'(oVS),   32'(e2.vs));
        chk("oDE",   32'(oDE),   32'(e2.de));
        chk("oCE",   32'(oCE),   32'(e2.ce));
        chk("oHPOL", 32'(oHPOL), 32'(mHpol));
        chk("oVPOL", 32'(oVPOL), 32'(mVpol));
    endtask

    task automatic doReset();
        iRST_N = 1'b0;
        resetModel();
        cyc();
        cyc();
        iRST_N = 1'b1;
    endtask

    // ---------------- DE / latency vectors ----------------
    typedef struct {
        logic        hb, vb;
        logic [23:0] rgb;
        logic        expDe;
        logic [23:0] expRgb;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int hiCnt, ceCnt, tIn, tHs, tO;

        vecs[0] = '{1'b0, 1'b0, 24'h123456, 1'b1, 24'h123456};
        vecs[1] = '{1'b0, 1'b1, 24'h123456, 1'b0, 24'h123456};
        vecs[2] = '{1'b1, 1'b0, 24'hABCDEF, 1'b0, 24'hABCDEF};
        vecs[3] = '{1'b1, 1'b1, 24'h000001, 1'b0, 24'h000001};
        vecs[4] = '{1'b0, 1'b0, 24'hFFFFFF, 1'b1, 24'hFFFFFF};
        vecs[5] = '{1'b0, 1'b0, 24'h800000, 1'b1, 24'h800000};

        iRST_N = 1'b0; iCE = 1'b0; iRGB = '0; iHS = 1'b0; iVS = 1'b0;
        iHBLANK = 1'b0; iVBLANK = 1'b0;
        resetModel();
        cyc(); cyc();

        // ---- reset: release, then assert asynchronously mid-line ----
        iRST_N = 1'b1; iCE = 1'b1; iHS = 1'b1; iRGB = 24'hFFFFFF;
        cyc();
        chk("post_reset_lat1", 32'(oRGB), 32'h0);
        cyc();
        chk("post_reset_lat2", 32'(oRGB), 32'hFFFFFF);
        repeat (5) cyc();
        #3 iRST_N = 1'b0;
        #1;
        chk("async_rst_rgb", 32'(oRGB), 32'h0);
        chk("async_rst_hs",  32'(oHS),  32'h0);
        chk("async_rst_de",  32'(oDE),  32'h0);
        chk("async_rst_ce",  32'(oCE),  32'h0);
        chk("async_rst_pol", 32'({oHPOL, oVPOL}), 32'h0);
        resetModel();
        cyc(); cyc();
        iRST_N = 1'b1;
        cyc();
        chk("release_lat1", 32'(oRGB), 32'h0);
        cyc();
        chk("release_lat2", 32'(oRGB), 32'hFFFFFF);

        // ---- DE / latency table ----
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                iHBLANK = vecs[i].hb; iVBLANK = vecs[i].vb; iRGB = vecs[i].rgb;
            end
            cyc();
            if (i >= 1) begin
                chk("vec_de",  32'(oDE),  32'(vecs[i-1].expDe));
                chk("vec_rgb", 32'(oRGB), 32'(vecs[i-1].expRgb));
            end
        end
        iHBLANK = 1'b0; iVBLANK = 1'b0;

        // ---- active-low HS: 800-clock line, 96 clocks low ----
        doReset();
        iCE = 1'b1; iVS = 1'b0;
        hiCnt = 0;
        for (int ln = 0; ln < 4; ln++)
            for (int x = 0; x < 800; x++) begin
                iHS = (x >= 96); iRGB = 24'($urandom);
                cyc();
                if (ln == 3 && oHS) hiCnt++;
            end
        chk("hs_actlow_pol", 32'(oHPOL), 32'h1);
        chk("hs_actlow_width", 32'(hiCnt), 32'd96);

        // ---- active-high VS: 525-line frame, VS high 2 lines ----
        doReset();
        iCE = 1'b1;
        hiCnt = 0;
        for (int fr = 0; fr < 2; fr++)
            for (int ln = 0; ln < 525; ln++)
                for (int x = 0; x < 16; x++) begin
                    iHS = (x < 2); iVS = (ln < 2);
                    cyc();
                    if (fr == 1 && oVS) hiCnt++;
                end
        cyc();
        chk("vs_acthigh_pol", 32'(oVPOL), 32'h0);
        chk("vs_acthigh_width", 32'(hiCnt), 32'd32);

        // ---- CE gating: CE every 4th clock ----
        doReset();
        iVS = 1'b0; ceCnt = 0;
        for (int ln = 0; ln < 3; ln++)
            for (int c = 0; c < 400; c++)
                for (int s = 0; s < 4; s++) begin
                    iCE = (s == 0); iHS = (c >= 48);
                    cyc();
                    if (ln == 2 && oCE) ceCnt++;
                end
        chk("ce_gated_pol", 32'(oHPOL), 32'h1);
        chk("ce_gated_count", 32'(ceCnt), 32'd400);

        // ---- saturation: both halves exceed counter range -> tie ----
        doReset();
        iCE = 1'b1; iHS = 1'b0;
        repeat (5) cyc();
        iHS = 1'b1; repeat (4300) cyc();
        iHS = 1'b0; repeat (4200) cyc();
        iHS = 1'b1; cyc(); cyc();
        chk("sat_tie_pol", 32'(oHPOL), 32'h0);

        // ---- VS alignment to HS leading edge ----
        doReset();
        iCE = 1'b1; iVS = 1'b0;
        tIn = -1; tHs = -1; tO = -1;
        for (int ln = 0; ln < 4; ln++)
            for (int x = 0; x < 200; x++) begin
                iHS = (x < 20);
                if (ln == 1 && x == 100) begin iVS = 1'b1; tIn = cycIdx; end
                if (ln == 2 && x == 0) tHs = cycIdx;
                cyc();
                if (oVS && tO < 0) tO = cycIdx;
            end
`ifdef VIDEO_NORM_VSALIGN_EN
        chk("vsalign_delay", 32'(tO - tHs), 32'd2);
`else
        chk("vs_passthru_delay", 32'(tO - tIn), 32'd2);
`endif
        iVS = 1'b0;

        // ---- randomized frames against the model (no reset between) ----
        for (int cfg = 0; cfg < 6; cfg++) begin
            bit hp, vp, ceRand;
            int L, hw, F, vw;
            hp = 1'($urandom); vp = 1'($urandom); ceRand = 1'($urandom);
            L  = $urandom_range(20, 48); hw = $urandom_range(2, 6);
            F  = $urandom_range(6, 14);  vw = $urandom_range(1, 2);
            for (int fr = 0; fr < 3; fr++)
                for (int ln = 0; ln < F; ln++)
                    for (int x = 0; x < L; x++) begin
                        iHS = (x < hw) ^ hp;
                        iVS = (ln < vw) ^ vp;
                        iCE = ceRand ? ($urandom_range(0, 3) != 0) : 1'b1;
                        iHBLANK = (x >= L - 4);
                        iVBLANK = (ln >= F - 1);
                        iRGB = 24'($urandom);
                        cyc();
                    end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
